// File: rtl/key_pulse_conditioner_if.sv
// Key conditioner handshake bundle: raw key and repeat enable in,
// count/release strobes and debounced level out.
`timescale 1ns/1ps
interface key_pulse_conditioner_if;
  logic key_in;
  logic rep_en;
  logic cou;
  logic rel;
  logic key_level;

  modport master (
    output key_in,
    output rep_en,
    input  cou,
    input  rel,
    input  key_level
  );

  modport slave (
    input  key_in,
    input  rep_en,
    output cou,
    output rel,
    output key_level
  );
endinterface

// File: rtl/key_pulse_conditioner.sv
// Debounces a mechanical key and emits count strobes on press and
// auto-repeat, plus a release strobe, through a single shared counter.
`timescale 1ns/1ps
module key_pulse_conditioner #(
  parameter int unsigned DEB_CYCLES   = 500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic                    clk,
  input  logic                    res,
  key_pulse_conditioner_if.slave  bus
);

  localparam int unsigned CW = 25;

  if (DEB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_min
    $error("key_pulse_conditioner: parameters must be >= 2");
  end
  if (DEB_CYCLES > 33554432 || REPEAT_DELAY > 33554432 ||
      REPEAT_RATE > 33554432) begin : g_bad_max
    $error("key_pulse_conditioner: parameter exceeds counter range");
  end

  // The IDLE sample counts as the first stable sample, so the
  // debounce states only need DEB_CYCLES-1 further samples.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 2);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_REL
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_cou;
  logic          r_rel;
  logic          r_level;
  logic          w_cou_nxt;
  logic          w_rel_nxt;
  logic          w_level_nxt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cou   <= 1'b0;
      r_rel   <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= bus.key_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cou   <= w_cou_nxt;
      r_rel   <= w_rel_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 25'd1;
    w_cou_nxt   = 1'b0;
    w_rel_nxt   = 1'b0;
    w_level_nxt = r_level;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_sync2) w_state_nxt = DB_PRESS;
      end
      DB_PRESS: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_cou_nxt   = 1'b1;
          w_level_nxt = 1'b1;
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nxt = DB_REL;
          w_cnt_nxt   = '0;
        end else if (!bus.rep_en) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == RD_LAST) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_cou_nxt   = 1'b1;
        end
      end
      REPEAT: begin
        if (!r_sync2) begin
          w_state_nxt = DB_REL;
          w_cnt_nxt   = '0;
        end else if (!bus.rep_en) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RR_LAST) begin
          w_cnt_nxt = '0;
          w_cou_nxt = 1'b1;
        end
      end
      DB_REL: begin
        if (r_sync2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
          w_level_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.cou       = r_cou;
  assign bus.rel       = r_rel;
  assign bus.key_level = r_level;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEB_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3.
`timescale 1ns/1ps
module tb_key_pulse_conditioner;

  logic clk;
  logic res;
  int   n_tests;
  int   n_fail;

  key_pulse_conditioner_if bus ();

  key_pulse_conditioner #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k counts posedges since key_in was changed at a negedge.
  task automatic test_reset();
    res = 1'b0;
    bus.key_in = 1'b0;
    bus.rep_en = 1'b0;
    #12;
    n_tests++;
    if (bus.cou !== 1'b0) begin
      $display("FAIL reset_cou got %b want 0", bus.cou); n_fail++;
    end
    n_tests++;
    if (bus.rel !== 1'b0) begin
      $display("FAIL reset_rel got %b want 0", bus.rel); n_fail++;
    end
    n_tests++;
    if (bus.key_level !== 1'b0) begin
      $display("FAIL reset_level got %b want 0", bus.key_level); n_fail++;
    end
    @(negedge clk);
    res = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.cou, bus.rel, bus.key_level} !== 3'b000) begin
      $display("FAIL reset_idle got %b want 000",
               {bus.cou, bus.rel, bus.key_level}); n_fail++;
    end
  endtask

  task automatic test_clean_press();
    logic ec, er, el;
    bus.rep_en = 1'b0;
    bus.key_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ec = (k == 6);
      er = (k == 14);
      el = (k >= 6 && k < 14);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== {ec, er, el}) begin
        $display("FAIL clean_press k=%0d got cou/rel/lvl=%b%b%b want %b%b%b",
                 k, bus.cou, bus.rel, bus.key_level, ec, er, el);
        n_fail++;
      end
      if (k == 8) bus.key_in = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [2:0] pat;
    pat = 3'b110;
    bus.rep_en = 1'b0;
    for (int k = 0; k < 24; k++) begin
      bus.key_in = (k < 15) ? pat[2 - (k % 3)] : 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== 3'b000) begin
        $display("FAIL glitch k=%0d got cou/rel/lvl=%b%b%b want 000",
                 k, bus.cou, bus.rel, bus.key_level);
        n_fail++;
      end
    end
  endtask

  task automatic test_release_bounce();
    logic ec, er, el;
    bus.rep_en = 1'b0;
    bus.key_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      ec = (k == 6);
      er = (k == 22);
      el = (k >= 6 && k < 22);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== {ec, er, el}) begin
        $display("FAIL rel_bounce k=%0d got cou/rel/lvl=%b%b%b want %b%b%b",
                 k, bus.cou, bus.rel, bus.key_level, ec, er, el);
        n_fail++;
      end
      if (k == 8)  bus.key_in = 1'b0;
      if (k == 10) bus.key_in = 1'b1;
      if (k == 16) bus.key_in = 1'b0;
    end
  endtask

  task automatic test_repeat();
    logic ec, er, el;
    bus.rep_en = 1'b1;
    bus.key_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ec = (k == 6) || (k >= 16 && k <= 31 && (k - 16) % 3 == 0);
      er = (k == 36);
      el = (k >= 6 && k < 36);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== {ec, er, el}) begin
        $display("FAIL repeat k=%0d got cou/rel/lvl=%b%b%b want %b%b%b",
                 k, bus.cou, bus.rel, bus.key_level, ec, er, el);
        n_fail++;
      end
      if (k == 30) bus.key_in = 1'b0;
    end
    bus.rep_en = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    logic ec, er, el;
    bus.rep_en = 1'b1;
    bus.key_in = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    res = 1'b0;
    #1;
    n_tests++;
    if ({bus.cou, bus.rel, bus.key_level} !== 3'b000) begin
      $display("FAIL async_reset got cou/rel/lvl=%b%b%b want 000",
               bus.cou, bus.rel, bus.key_level);
      n_fail++;
    end
    repeat (2) @(negedge clk);
    res = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ec = (k == 6);
      er = (k == 14);
      el = (k >= 6 && k < 14);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== {ec, er, el}) begin
        $display("FAIL post_reset k=%0d got cou/rel/lvl=%b%b%b want %b%b%b",
                 k, bus.cou, bus.rel, bus.key_level, ec, er, el);
        n_fail++;
      end
      if (k == 8) bus.key_in = 1'b0;
    end
    bus.rep_en = 1'b0;
  endtask

  task automatic test_rep_disable();
    logic ec, er, el;
    bus.rep_en = 1'b1;
    bus.key_in = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      ec = (k == 6) || (k == 16) || (k == 35) || (k == 38) || (k == 41);
      er = (k == 45);
      el = (k >= 6 && k < 45);
      n_tests++;
      if ({bus.cou, bus.rel, bus.key_level} !== {ec, er, el}) begin
        $display("FAIL rep_disable k=%0d got cou/rel/lvl=%b%b%b want %b%b%b",
                 k, bus.cou, bus.rel, bus.key_level, ec, er, el);
        n_fail++;
      end
      if (k == 17) bus.rep_en = 1'b0;
      if (k == 25) bus.rep_en = 1'b1;
      if (k == 39) bus.key_in = 1'b0;
    end
    bus.rep_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clean_press();
    repeat (3) @(negedge clk);
    test_glitch();
    repeat (3) @(negedge clk);
    test_release_bounce();
    repeat (3) @(negedge clk);
    test_repeat();
    repeat (3) @(negedge clk);
    test_reset_mid_repeat();
    repeat (3) @(negedge clk);
    test_rep_disable();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_pulse_conditioner.md
KEY_PULSE_CONDITIONER -- requirements
Module: key_pulse_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000, giving the number of consecutive stable synchronized samples required to accept a press or a release (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the number of held cycles from the accepted press to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 5000000, giving the number of cycles between successive auto-repeat pulses.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 res  input  1  asynchronous, active-low reset.
REQ-006 key_in  input  1  raw mechanical key, asynchronous to clk, 1 = pressed.
REQ-007 rep_en  input  1  auto-repeat enable, synchronous to clk.
REQ-008 cou  output  1  one-cycle count strobe, asserted on an accepted press and on each auto-repeat; it feeds the downstream counter/display stage.
REQ-009 rel  output  1  one-cycle strobe on an accepted release.
REQ-010 key_level  output  1  debounced key level.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer; only the second flop (key_s) SHALL be used by the FSM.
REQ-012 The FSM SHALL have the states IDLE, DB_PRESS, HELD, REPEAT and DB_REL, with a single 25-bit counter cnt shared between states.
REQ-013 IDLE: key_s=1 SHALL cause a transition to DB_PRESS with cnt=0; otherwise the FSM SHALL stay in IDLE.
REQ-014 DB_PRESS: key_s=0 SHALL cause a return to IDLE with cnt=0; otherwise cnt SHALL increment, and on the edge where cnt=DEB_CYCLES-1 the FSM SHALL go to HELD with cnt=0, key_level=1 and cou=1 for one cycle.
REQ-015 HELD: key_s=0 SHALL cause a transition to DB_REL with cnt=0.
REQ-016 HELD, key held: if rep_en=1 and cnt=REPEAT_DELAY-1, the FSM SHALL go to REPEAT with cnt=0 and cou=1; otherwise cnt SHALL increment.
REQ-017 REPEAT: key_s=0 SHALL cause a transition to DB_REL with cnt=0.
REQ-018 REPEAT, key held: at cnt=REPEAT_RATE-1, cou=1 and cnt=0; otherwise cnt SHALL increment.
REQ-019 REPEAT: rep_en dropping to 0 SHALL cause a return to HELD with cnt=0.
REQ-020 DB_REL: key_s=1 SHALL cause a return to HELD with cnt=0 (the bounce is rejected and no strobe is issued).
REQ-021 DB_REL: otherwise cnt SHALL increment, and at cnt=DEB_CYCLES-1 the FSM SHALL go to IDLE with key_level=0 and rel=1 for one cycle.
REQ-022 cou and rel SHALL be registered outputs, SHALL never be high for more than one consecutive cycle, and SHALL never be high in the same cycle.
REQ-023 Latency from a clean key_in edge to the cou or rel strobe SHALL be DEB_CYCLES+2 clock edges.
REQ-024 key_level SHALL change in the same cycle as the corresponding strobe.
REQ-025 cnt SHALL never exceed max(DEB_CYCLES, REPEAT_DELAY, REPEAT_RATE)-1; no wrap-around SHALL occur.
REQ-026 rep_en=0 in HELD SHALL freeze cnt at 0, so a later rep_en=1 restarts the full REPEAT_DELAY.
REQ-027 Parameters equal to 0 or 1 are illegal; the block SHALL flag them with a simulation-time error.

Reset
REQ-028 res=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, both synchronizer flops=0, and cou=0, rel=0, key_level=0.
REQ-029 A reset asserted mid-press or mid-repeat SHALL discard all progress and SHALL produce no strobe at deassertion.
REQ-030 After deassertion, a key already held SHALL be treated as a new press and SHALL complete a full debounce.

Verification (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-031 Clean press held 8 cycles, then released -> exactly one cou pulse 6 edges after press; key_level=1; one rel 6 edges after release; key_level=0.
REQ-032 Press with 2-cycle glitches (high 2, low 1, repeated) -> no cou, key_level stays 0, FSM oscillates between IDLE and DB_PRESS.
REQ-033 rep_en=1, key held 30 cycles -> cou at press acceptance, after 10 more cycles, then every 3 cycles; single-cycle strobes only.
REQ-034 Release bounce (low 2, high 1) while HELD -> no rel, key_level stays 1, back in HELD.
REQ-035 res=0 pulsed during REPEAT -> all outputs 0 with no clock edge; key still held -> new cou DEB_CYCLES+2 edges after deassertion.
REQ-036 rep_en toggled 1->0 in REPEAT -> no further cou; HELD with cnt=0; re-enable -> first repeat 10 cycles later.
